// File: rtl/stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_fetch
// Description : First pipeline stage. Owns the program counter and issues
//               instruction-memory reads. Memory answers one cycle later, so
//               o_valid / o_pc_plus_2 are registered to line up with mem_data.
//               Handles downstream stalls and taken-branch redirects.
// Revision    : 1.0 - initial release
//
// Parameters:
//   RESET_PC  - PC loaded on reset (bit 0 ignored, word aligned)
//   PC_STEP   - byte increment per sequential fetch
//
// Ports:
//   clk               - clock, rising edge
//   reset             - asynchronous active-high reset
//   i_stall           - hold fetch (re-read the same address)
//   i_branch_taken    - branch/jump resolved taken this cycle
//   i_branch_target   - redirect PC (bit 0 forced to 0)
//   o_pc_addr         - instruction memory address (the PC register)
//   o_pc_rd           - instruction memory read strobe
//   o_valid           - mem_data this cycle is a valid fetch
//   o_pc_plus_2       - PC+2 of the instruction currently on mem_data
//   o_squash_rf_read  - kill the instruction now in rf_read
//   o_fetch_count     - non-stalled read count (FETCH_PERF_CNT_EN only)
//
// Configuration macro:
//   FETCH_PERF_CNT_EN - adds the saturating o_fetch_count performance counter
// ============================================================================
module stage_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    output logic [15:0] o_pc_addr,
    output logic        o_pc_rd,
    output logic        o_valid,
    output logic [15:0] o_pc_plus_2,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] o_fetch_count,
`endif
    output logic        o_squash_rf_read
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};
    localparam logic [15:0] STEP    = 16'(PC_STEP);

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic        valid_nxt;
    logic [15:0] plus2_nxt;
    logic [15:0] pc_seq;

    // Natural 16-bit wrap: 16'hFFFE + 2 -> 16'h0000.
    assign pc_seq = pc + STEP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= PC_INIT;
            o_valid     <= 1'b0;
            o_pc_plus_2 <= 16'h0000;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            o_valid     <= valid_nxt;
            o_pc_plus_2 <= plus2_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = o_valid;
        plus2_nxt = o_pc_plus_2;
        o_pc_rd   = 1'b0;

        case (state)
            BOOT: begin
                // No read issued, so nothing arrives next cycle.
                valid_nxt = 1'b0;
                if (i_branch_taken) begin
                    pc_nxt    = {i_branch_target[15:1], 1'b0};
                    state_nxt = REDIRECT;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN, REDIRECT: begin
                o_pc_rd = 1'b1;
                if (i_branch_taken) begin
                    // The read issued this cycle is wrong-path: drop it.
                    pc_nxt    = {i_branch_target[15:1], 1'b0};
                    valid_nxt = 1'b0;
                    state_nxt = REDIRECT;
                end else if (i_stall) begin
                    // Same address is re-read, so mem_data repeats; hold
                    // everything including the state.
                    state_nxt = state;
                end else begin
                    pc_nxt    = pc_seq;
                    valid_nxt = 1'b1;
                    plus2_nxt = pc_seq;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign o_pc_addr        = pc;
    assign o_squash_rf_read = i_branch_taken;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_fetch_count <= 32'h0000_0000;
        end else if (o_pc_rd && !i_stall && (o_fetch_count != 32'hFFFF_FFFF)) begin
            o_fetch_count <= o_fetch_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_fetch
// Description : Directed self-checking bench for stage_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_fetch;

    logic        clk;
    logic        reset;
    logic        i_stall;
    logic        i_branch_taken;
    logic [15:0] i_branch_target;
    logic [15:0] o_pc_addr;
    logic        o_pc_rd;
    logic        o_valid;
    logic [15:0] o_pc_plus_2;
    logic        o_squash_rf_read;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    stage_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .i_stall          (i_stall),
        .i_branch_taken   (i_branch_taken),
        .i_branch_target  (i_branch_target),
        .o_pc_addr        (o_pc_addr),
        .o_pc_rd          (o_pc_rd),
        .o_valid          (o_valid),
        .o_pc_plus_2      (o_pc_plus_2),
`ifdef FETCH_PERF_CNT_EN
        .o_fetch_count    (o_fetch_count),
`endif
        .o_squash_rf_read (o_squash_rf_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the fetch-side outputs in one go.
    task automatic chk_fetch(input string tag, input logic [15:0] addr,
                             input logic rd, input logic vld, input logic [15:0] p2);
        chk({tag, ".addr"},  {16'h0, o_pc_addr},   {16'h0, addr});
        chk({tag, ".rd"},    {31'h0, o_pc_rd},     {31'h0, rd});
        chk({tag, ".valid"}, {31'h0, o_valid},     {31'h0, vld});
        chk({tag, ".plus2"}, {16'h0, o_pc_plus_2}, {16'h0, p2});
    endtask

    initial begin
        reset           = 1'b1;
        i_stall         = 1'b0;
        i_branch_taken  = 1'b0;
        i_branch_target = 16'h0000;
        tick();
        tick();
        chk_fetch("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
        chk("reset.count", o_fetch_count, 32'd0);
`endif
        reset = 1'b0;
        #1;
        // BOOT cycle: no read issued
        chk_fetch("boot", 16'h0000, 1'b0, 1'b0, 16'h0000);
        tick();
        chk_fetch("run0", 16'h0000, 1'b1, 1'b0, 16'h0000);
        tick();
        chk_fetch("run2", 16'h0002, 1'b1, 1'b1, 16'h0002);
        tick();
        chk_fetch("run4", 16'h0004, 1'b1, 1'b1, 16'h0004);
        tick();
        chk_fetch("run6", 16'h0006, 1'b1, 1'b1, 16'h0006);
        tick();
        chk_fetch("run8", 16'h0008, 1'b1, 1'b1, 16'h0008);

        // Stall three cycles at pc=8
        i_stall = 1'b1;
        tick();
        chk_fetch("stall1", 16'h0008, 1'b1, 1'b1, 16'h0008);
        tick();
        chk_fetch("stall2", 16'h0008, 1'b1, 1'b1, 16'h0008);
        tick();
        chk_fetch("stall3", 16'h0008, 1'b1, 1'b1, 16'h0008);
        i_stall = 1'b0;
        tick();
        chk_fetch("resume10", 16'h000A, 1'b1, 1'b1, 16'h000A);
        tick();
        chk_fetch("run12", 16'h000C, 1'b1, 1'b1, 16'h000C);

        // Taken branch to 0x41 at pc=12 (bit 0 dropped)
        i_branch_taken  = 1'b1;
        i_branch_target = 16'h0041;
        #1;
        chk("br.squash", {31'h0, o_squash_rf_read}, 32'd1);
        tick();
        i_branch_taken = 1'b0;
        #1;
        chk("br.squash_off", {31'h0, o_squash_rf_read}, 32'd0);
        chk_fetch("br.redir", 16'h0040, 1'b1, 1'b0, 16'h000C);
        tick();
        chk_fetch("br.tgt", 16'h0042, 1'b1, 1'b1, 16'h0042);

        // Branch and stall together: branch wins
        i_branch_taken  = 1'b1;
        i_stall         = 1'b1;
        i_branch_target = 16'h0100;
        tick();
        i_branch_taken = 1'b0;
        i_stall        = 1'b0;
        chk_fetch("brst.redir", 16'h0100, 1'b1, 1'b0, 16'h0042);
        tick();
        chk_fetch("brst.tgt", 16'h0102, 1'b1, 1'b1, 16'h0102);

        // Back-to-back branches 0x20 then 0x30
        i_branch_taken  = 1'b1;
        i_branch_target = 16'h0020;
        tick();
        chk_fetch("b2b.first", 16'h0020, 1'b1, 1'b0, 16'h0102);
        i_branch_target = 16'h0030;
        tick();
        i_branch_taken = 1'b0;
        chk_fetch("b2b.second", 16'h0030, 1'b1, 1'b0, 16'h0102);
        tick();
        chk_fetch("b2b.tgt", 16'h0032, 1'b1, 1'b1, 16'h0032);

        // PC wrap at 0xFFFE
        i_branch_taken  = 1'b1;
        i_branch_target = 16'hFFFE;
        tick();
        i_branch_taken = 1'b0;
        chk_fetch("wrap.redir", 16'hFFFE, 1'b1, 1'b0, 16'h0032);
        tick();
        chk_fetch("wrap.zero", 16'h0000, 1'b1, 1'b1, 16'h0000);
        tick();
        chk_fetch("wrap.two", 16'h0002, 1'b1, 1'b1, 16'h0002);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk_fetch("areset", 16'h0000, 1'b0, 1'b0, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
        chk("areset.count", o_fetch_count, 32'd0);
`endif
        tick();

        // Branch during BOOT
        reset           = 1'b0;
        i_branch_taken  = 1'b1;
        i_branch_target = 16'h0050;
        #1;
        chk("boot.squash", {31'h0, o_squash_rf_read}, 32'd1);
        tick();
        i_branch_taken = 1'b0;
        chk_fetch("bootbr.redir", 16'h0050, 1'b1, 1'b0, 16'h0000);
        tick();
        chk_fetch("bootbr.tgt", 16'h0052, 1'b1, 1'b1, 16'h0052);

`ifdef FETCH_PERF_CNT_EN
        // 10 read cycles, 2 of them stalled -> 8 counted.
        // Reset again so the count starts from zero at a known point.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();   // BOOT cycle elapsed, now RUN with rd=1
        for (int i = 0; i < 10; i++) begin
            i_stall = (i == 3 || i == 6);
            tick();
        end
        i_stall = 1'b0;
        chk("perf.count", o_fetch_count, 32'd8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
